// File: rtl/output_buffer_reader_pkg.sv
// Shared systolic-array package: drain FSM state encoding and default output buffer geometry.
package output_buffer_reader_pkg;

  localparam int OBUF_DEPTH  = 16;
  localparam int OBUF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } obuf_state_t;

endpackage

// File: rtl/output_buffer_reader_obuf_mem.sv
// Output buffer storage: DEPTH x DATA_W array with one write port, one registered read port
// and a per-entry valid bit (a write wins over a same-cycle clear of the same entry).
module obuf_mem
  import output_buffer_reader_pkg::*;
#(
  parameter int DEPTH  = OBUF_DEPTH,
  parameter int DATA_W = OBUF_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DEPTH-1:0]  valid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  valid_next;

  // Payload array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_next[gi] = (wr_en && (wr_addr == AW'(gi))) ? 1'b1 :
                              (clr_en && (clr_addr == AW'(gi))) ? 1'b0 :
                              valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  assign valid = valid_reg;

endmodule

// File: rtl/output_buffer_reader.sv
// Drains accumulated results from the output buffer in index order over a valid/ready port.
// Optional feature macro: OBUF_OVERWRITE_DETECT_EN adds the sticky overwrite_err output.
module output_buffer_reader
  import output_buffer_reader_pkg::*;
#(
  parameter int DEPTH  = OBUF_DEPTH,
  parameter int DATA_W = OBUF_DATA_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_start,
  input  logic [AW-1:0]     drain_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_addr,
  output logic              busy,
  output logic              drain_done
`ifdef OBUF_OVERWRITE_DETECT_EN
  ,
  output logic              overwrite_err
`endif
);

  obuf_state_t   state_reg, state_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic [AW:0]   remaining_reg, remaining_next;
  logic [AW-1:0] out_addr_reg, out_addr_next;
  logic          out_valid_reg, out_valid_next;
  logic          drain_done_reg, drain_done_next;
  logic          handshake;
  logic          load;
  logic [DEPTH-1:0] valid;

  assign handshake = (state_reg == ST_SEND) && out_valid_reg && out_ready;

  obuf_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_en   (handshake),
    .clr_addr (rd_addr_reg),
    .rd_en    (load),
    .rd_addr  (rd_addr_reg),
    .rd_data  (out_data),
    .valid    (valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rd_addr_reg    <= '0;
      remaining_reg  <= '0;
      out_addr_reg   <= '0;
      out_valid_reg  <= 1'b0;
      drain_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rd_addr_reg    <= rd_addr_next;
      remaining_reg  <= remaining_next;
      out_addr_reg   <= out_addr_next;
      out_valid_reg  <= out_valid_next;
      drain_done_reg <= drain_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rd_addr_next    = rd_addr_reg;
    remaining_next  = remaining_reg;
    out_addr_next   = out_addr_reg;
    out_valid_next  = out_valid_reg;
    drain_done_next = 1'b0;
    load            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (drain_start) begin
          // A zero count requests a full-buffer drain.
          remaining_next = (drain_count == '0) ? (AW+1)'(DEPTH) : {1'b0, drain_count};
          rd_addr_next   = '0;
          state_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (valid[rd_addr_reg]) begin
          load           = 1'b1;
          out_addr_next  = rd_addr_reg;
          out_valid_next = 1'b1;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (handshake) begin
          out_valid_next = 1'b0;
          rd_addr_next   = rd_addr_reg + 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == (AW+1)'(1)) begin
            drain_done_next = 1'b1;
            state_next      = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_valid  = out_valid_reg;
  assign out_addr   = out_addr_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign drain_done = drain_done_reg;

`ifdef OBUF_OVERWRITE_DETECT_EN
  logic overwrite_err_reg;

  // An entry being cleared by the handshake this cycle is free to be rewritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overwrite_err_reg <= 1'b0;
    end else if (wr_en && valid[wr_addr] && !(handshake && (rd_addr_reg == wr_addr))) begin
      overwrite_err_reg <= 1'b1;
    end
  end

  assign overwrite_err = overwrite_err_reg;
`endif

endmodule

// File: doc/output_buffer_reader.md
OUTPUT_BUFFER_READER -- requirements
Module: output_buffer_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of buffer entries (power of two).
REQ-002 SHALL have parameter DATA_W, default 32, entry width in bits.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1, write strobe from the accumulator side.
REQ-006 SHALL have port wr_addr, input, log2(DEPTH), write entry index.
REQ-007 SHALL have port wr_data, input, DATA_W, write payload.
REQ-008 SHALL have port drain_start, input, 1, single-cycle request to begin a drain.
REQ-009 SHALL have port drain_count, input, log2(DEPTH), number of entries to drain; 0 means DEPTH.
REQ-010 SHALL have port out_valid, output, 1, out_data holds a drained entry.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-012 SHALL have port out_data, output, DATA_W, drained payload.
REQ-013 SHALL have port out_addr, output, log2(DEPTH), index of the entry on out_data.
REQ-014 SHALL have port busy, output, 1, high while not IDLE.
REQ-015 SHALL have port drain_done, output, 1, single-cycle pulse when the final entry is accepted.

Function
REQ-016 SHALL store wr_data at wr_addr on a clk edge with wr_en=1 and set that entry's valid bit; the bit is visible the next cycle.
REQ-017 SHALL implement FSM IDLE -> WAIT -> SEND -> (WAIT | IDLE).
REQ-018 SHALL, in IDLE, on drain_start=1 latch drain_count, set rd_addr=0, and go to WAIT.
REQ-019 SHALL, in WAIT, go to SEND when valid[rd_addr]=1, registering out_data=mem[rd_addr] and out_addr=rd_addr; out_valid asserts the following cycle.
REQ-020 SHALL, in SEND, hold out_valid, out_data and out_addr stable until out_valid&out_ready.
REQ-021 SHALL, on handshake, clear valid[rd_addr], increment rd_addr modulo DEPTH, and decrement remaining.
REQ-022 SHALL, on the handshake when remaining reaches zero, pulse drain_done for one cycle and return to IDLE; otherwise return to WAIT.
REQ-023 SHALL ignore drain_start when not in IDLE.
REQ-024 SHALL let a write win on the same cycle as a handshake-clear of the same entry: valid stays 1 with the new data.
REQ-025 SHALL, when out_ready is held high, sustain at most one accepted entry every two cycles (SEND -> WAIT -> SEND).
REQ-026 SHALL accept writes in every state without stalling.

Reset
REQ-027 SHALL, on rst=1, asynchronously force state=IDLE, all valid bits=0, rd_addr=0, out_valid=0, out_data=0, out_addr=0, busy=0, drain_done=0; memory contents are not reset.
REQ-028 SHALL, on rst mid-drain, abandon the drain with no drain_done pulse.

Configuration
REQ-029 SHALL, with OBUF_OVERWRITE_DETECT_EN defined, add output overwrite_err (1 bit, sticky until rst), set when wr_en targets an entry whose valid bit is already 1 and not being cleared in the same cycle.
REQ-030 SHALL, without OBUF_OVERWRITE_DETECT_EN, omit overwrite_err and its logic; overwrites replace data silently.

Structure
REQ-031 SHALL place the FSM state enum and the default DEPTH/DATA_W constants in the shared systolic package.
REQ-032 SHALL implement storage as one sub-module, obuf_mem: DEPTH x DATA_W, one write port, one read port, with a per-entry valid-bit array.

Verification
REQ-033 SHALL cover: write 0x3F800000@0..3, drain_start count=4, out_ready=1 -> out_addr 0,1,2,3 with matching data, then one drain_done pulse and busy=0.
REQ-034 SHALL cover: drain count=2 with entry 1 unwritten -> FSM waits in WAIT after entry 0; write 0x40000000@1 -> out_valid two cycles later with that data.
REQ-035 SHALL cover: out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_addr stable, no advance, no drain_done.
REQ-036 SHALL cover: count=0 with all 16 entries written -> 16 transfers, rd_addr wraps to 0, single drain_done.
REQ-037 SHALL cover: rst pulse mid-drain after 2 of 4 transfers -> out_valid=0, busy=0, no drain_done, all valid bits clear.
REQ-038 SHALL cover, with OBUF_OVERWRITE_DETECT_EN: two writes to entry 5 without a drain -> overwrite_err=1 and held until rst.
